// File: rtl/seg7_pkg.sv
// Shared types for the seven-segment byte sequencer: FSM state encoding and hex glyph table.
// Glyph bit order is {g,f,e,d,c,b,a}, active high.
package seg7_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIGH,
    ST_GAP1,
    ST_LOW,
    ST_GAP2
  } state_t;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble-to-glyph lookup for a seven-segment digit.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  assign glyph_o = GLYPH_TABLE[nibble_i];

endmodule

// File: rtl/seg7_byte_sequencer.sv
// Shows one byte on a single seven-segment digit as high nibble (with dp), gap, low nibble, gap.
// Optional macro SEG7SEQ_REPEAT_EN: replay the latched byte forever and accept new bytes during GAP2.
//
// state   | meaning
// IDLE    | waiting for a byte, display blank
// HIGH    | high nibble glyph shown, dp lit
// GAP1    | blank between nibbles
// LOW     | low nibble glyph shown
// GAP2    | blank after the byte (replay point in repeat builds)
module seg7_byte_sequencer
  import seg7_pkg::*;
#(
  parameter int PHASE_CYCLES = 5000000,
  parameter int GAP_CYCLES   = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic       busy
);

  localparam int MAX_CYCLES = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       byte_q;
  logic             xfer;
  logic [3:0]       nibble;
  logic [6:0]       glyph;

`ifdef SEG7SEQ_REPEAT_EN
  assign byte_ready = (state_q == ST_IDLE) || (state_q == ST_GAP2);
`else
  assign byte_ready = (state_q == ST_IDLE);
`endif

  assign xfer = byte_valid && byte_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      byte_q  <= 8'h00;
    end else if (xfer) begin
      // a transfer in GAP2 (repeat builds) wins over the terminal count
      byte_q  <= byte_in;
      state_q <= ST_HIGH;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: cnt_q <= '0;
        ST_HIGH:
          if (cnt_q == PHASE_LAST) begin
            state_q <= ST_GAP1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        ST_GAP1:
          if (cnt_q == GAP_LAST) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        ST_LOW:
          if (cnt_q == PHASE_LAST) begin
            state_q <= ST_GAP2;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        ST_GAP2:
          if (cnt_q == GAP_LAST) begin
`ifdef SEG7SEQ_REPEAT_EN
            state_q <= ST_HIGH;
`else
            state_q <= ST_IDLE;
`endif
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign nibble = (state_q == ST_HIGH) ? byte_q[7:4] : byte_q[3:0];

  seg7_hex_decoder u_hex_decoder (
    .nibble_i (nibble),
    .glyph_o  (glyph)
  );

  assign seg_out = ((state_q == ST_HIGH) || (state_q == ST_LOW)) ? glyph : 7'h00;
  assign dp_out  = (state_q == ST_HIGH);
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: doc/seg7_byte_sequencer.md
SEG7_BYTE_SEQUENCER -- requirements
Module: seg7_byte_sequencer

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 5000000, clock cycles each nibble is displayed (legal range 1 or more).
REQ-002 SHALL have parameter GAP_CYCLES, default 1000000, clock cycles of blank display after each nibble (legal range 1 or more).
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port byte_in, input, 8 bits, byte to display.
REQ-006 SHALL have port byte_valid, input, 1 bit, byte_in is valid.
REQ-007 SHALL have port byte_ready, output, 1 bit, the block can accept a byte.
REQ-008 SHALL have port seg_out, output, 7 bits, segments {g,f,e,d,c,b,a}, with bit0 = a, active high.
REQ-009 SHALL have port dp_out, output, 1 bit, decimal point, active high.
REQ-010 SHALL have port busy, output, 1 bit, a display sequence is in progress.

Function
REQ-011 SHALL implement the FSM states IDLE, HIGH, GAP1, LOW and GAP2.
REQ-012 SHALL, on a transfer, latch byte_in and enter HIGH on that edge; a transfer is a rising edge with byte_valid=1 and byte_ready=1.
REQ-013 SHALL assert byte_ready only in IDLE, plus in GAP2 when SEG7SEQ_REPEAT_EN is defined.
REQ-014 SHALL give HIGH and LOW a duration of exactly PHASE_CYCLES cycles each, and GAP1 and GAP2 exactly GAP_CYCLES cycles each.
REQ-015 SHALL use one phase counter, reset to 0 on every state entry, with advance at count = duration-1 and a width of $clog2 of the larger parameter, minimum 1 bit.
REQ-016 SHALL follow the transition order HIGH -> GAP1 -> LOW -> GAP2 -> IDLE, with GAP2 behaviour per REQ-027/028.
REQ-017 SHALL drive seg_out as the hex glyph of byte[7:4] in HIGH and byte[3:0] in LOW, and 0x00 in IDLE, GAP1 and GAP2.
REQ-018 SHALL use the glyph table 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-019 SHALL drive dp_out=1 only in HIGH, to mark the high nibble.
REQ-020 SHALL drive busy=1 in every state except IDLE.
REQ-021 SHALL decode outputs from registered state, counter and latched byte only, with no input-to-output combinational path except none; the first HIGH glyph appears in the cycle after the accepting edge.
REQ-022 SHALL ignore byte_valid while byte_ready=0; the latched byte is unchanged and nothing is queued.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force state=IDLE, counter=0 and latched byte=0x00.
REQ-024 SHALL hold reset values seg_out=0x00, dp_out=0, busy=0, byte_ready=1.
REQ-025 SHALL, on reset asserted mid-sequence, abort immediately; after release the block is in IDLE and the aborted byte is never shown.
REQ-026 SHALL NOT accept a byte on the first edge while rst_n is low.

Configuration
REQ-027 SHALL, without SEG7SEQ_REPEAT_EN defined, go from GAP2 at terminal count to IDLE, so each byte is displayed once.
REQ-028 SHALL, with SEG7SEQ_REPEAT_EN defined, go from GAP2 at terminal count to HIGH and replay the latched byte indefinitely; a transfer during GAP2 latches the new byte and enters HIGH with counter=0, and the transfer takes priority over the terminal count.

Structure
REQ-029 SHALL provide package seg7_pkg holding the state enum typedef and the 16-entry glyph constant table.
REQ-030 SHALL implement the nibble-to-glyph lookup as combinational sub-module seg7_hex_decoder (4-bit in, 7-bit out), instantiated once and fed by a nibble mux.

Verification
REQ-031 SHALL cover: PHASE_CYCLES=4, GAP_CYCLES=2, send 0xA5 at edge 0 -> cycles 1-4 seg=0x77, dp=1; cycles 5-6 seg=0x00; cycles 7-10 seg=0x6D, dp=0; cycles 11-12 seg=0x00; cycle 13 IDLE, busy=0, ready=1.
REQ-032 SHALL cover: byte_valid held high with 0x3C during the 0xA5 sequence -> 0x3C not latched; accepted only at cycle 13; first glyph 0x4F at cycle 14.
REQ-033 SHALL cover: rst_n pulsed low at cycle 6 of a sequence -> same cycle seg=0x00, busy=0, ready=1; the LOW glyph never appears.
REQ-034 SHALL cover: sweep bytes 0x01, 0x23, ..., 0xEF -> every glyph matches REQ-018 for both nibbles.
REQ-035 SHALL cover: with SEG7SEQ_REPEAT_EN, send 0xA5 with no further input -> the sequence repeats with period 12 cycles.
REQ-036 SHALL cover: with SEG7SEQ_REPEAT_EN, send 0x7E during GAP2 -> the next cycle shows seg=0x07, dp=1.
